// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   dmem_state_e    : responder FSM states (IDLE / WAIT / RESP)
//   DMEM_WORD_BYTES : bytes per memory word
//   dmem_addr_err() : flags a misaligned or out-of-range byte address
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  localparam int DMEM_WORD_BYTES = 4;

  // The limit is computed in 34 bits so that 4*DEPTH_WORDS cannot wrap
  // for any legal depth.
  function automatic logic dmem_addr_err(input logic [31:0] addr,
                                         input int unsigned depth_words);
    logic [33:0] limit;
    limit = 34'(depth_words) * 34'(DMEM_WORD_BYTES);
    return (addr[1:0] != 2'b00) || ({2'b00, addr} >= limit);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH_WORDS x 32 word storage.
//   clk    : clock, rising edge
//   clear  : synchronous clear of every word (has priority over the write)
//   we     : write enable; waddr / wdata : write port
//   raddr  : read index; rdata : combinational read data
module dmem_array #(
  parameter int DEPTH_WORDS = 16384,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Responder side of the CPU data-memory port. One request is accepted at a
// time. Each request completes a fixed LATENCY edges after it is accepted,
// and the response is then held until it is consumed.
//   clk, reset            : clock and synchronous active-high reset
//   req_valid / req_ready : request handshake (ready only in IDLE)
//   req_write, req_addr, req_wdata : request payload (byte address)
//   resp_valid / resp_ready : response handshake
//   resp_rdata, resp_error  : load data (0 for stores / errors), error flag
//   busy                    : high while a request is in flight (WAIT/RESP)
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 16384,
  parameter int LATENCY     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        busy
);

  localparam int AW    = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  dmem_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             write_q, write_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic [31:0]      resp_rdata_q, resp_rdata_d;
  logic             resp_error_q, resp_error_d;
  logic             busy_q, busy_d;

  logic             addr_err;
  logic [AW-1:0]    word_idx;
  logic [31:0]      mem_rdata;
  logic             access;
  logic             mem_we;

  // Address decoding always works from the latched request, so req_* may
  // change freely once the request has been accepted.
  assign addr_err = dmem_addr_err(addr_q, DEPTH_WORDS);
  assign word_idx = addr_q[2+AW-1:2];
  assign access   = (state_q == ST_WAIT) && (cnt_q == '0);
  // The store commits on the same edge that enters RESP. Reset has priority
  // inside the array, so a store interrupted by reset is dropped.
  assign mem_we   = access && write_q && !addr_err;

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .clear (reset),
    .we    (mem_we),
    .waddr (word_idx),
    .wdata (wdata_q),
    .raddr (word_idx),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_error_d = resp_error_q;
    busy_d       = busy_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          write_d     = req_write;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          cnt_d       = CNT_INIT;
          state_d     = ST_WAIT;
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_error_d = addr_err;
          // Stores and faulting accesses acknowledge with zero data.
          resp_rdata_d = (write_q || addr_err) ? 32'd0 : mem_rdata;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          busy_d       = 1'b0;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        resp_valid_d = 1'b0;
        req_ready_d  = 1'b1;
        busy_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_error = resp_error_q;
  assign busy       = busy_q;

endmodule
